// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
//
// Purpose:
//   Shared defaults and helpers for the register-file RAM and its word
//   storage cells. Keeping the default geometry here means the top and the
//   per-word register agree on widths without repeating literals.
//
// Contents:
//   DEFAULT_BUS_WIDTH      default data word width in bits
//   DEFAULT_ADDRESS_WIDTH  default address width in bits
//   ramDepth()             number of words addressed by a given address width
// ---------------------------------------------------------------------------
package ram_pkg;

    localparam int DEFAULT_BUS_WIDTH     = 8;
    localparam int DEFAULT_ADDRESS_WIDTH = 2;

    // Depth is a power of two so every address pattern selects a real word;
    // there is never an out-of-range read or write to guard against.
    function automatic int ramDepth(input int addressWidth);
        return 1 << addressWidth;
    endfunction

endpackage : ram_pkg

// File: rtl/ram_word.sv
// ---------------------------------------------------------------------------
// ram_word
//
// Purpose:
//   One storage word of the register-file RAM. A plain WIDTH-bit register
//   that clears to zero on reset and loads d on a rising clock edge when
//   its write enable is high.
//
// Ports:
//   clk  in   1      clock, loads on rising edge
//   rst  in   1      asynchronous active-high reset, clears q to 0
//   we   in   1      write enable for this word
//   d    in   WIDTH  data to load
//   q    out  WIDTH  stored value
// ---------------------------------------------------------------------------
module ram_word
    import ram_pkg::*;
#(
    parameter int WIDTH = DEFAULT_BUS_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset has priority over a simultaneous write, so a store issued while
    // reset is held leaves the word at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule : ram_word

// File: rtl/ram.sv
// ---------------------------------------------------------------------------
// ram
//
// Purpose:
//   Single-port, word-addressed register-file RAM holding 2**ADDRESS_WIDTH
//   words of BUS_WIDTH bits. Writes are synchronous on the rising edge of
//   clk when st is high; reads are asynchronous and always show the word
//   currently addressed by ad.
//
// Ports (positional order is ad, st, x, clk, o, rst so older five-port
// positional instantiations still line up):
//   ad   in   ADDRESS_WIDTH  word address, shared by read and write
//   st   in   1              store enable, writes x into the word at ad
//   x    in   BUS_WIDTH      write data
//   clk  in   1              clock, writes on rising edge only
//   o    out  BUS_WIDTH      read data, combinational view of mem[ad]
//   rst  in   1              asynchronous active-high reset, clears all words
// ---------------------------------------------------------------------------
module ram
    import ram_pkg::*;
#(
    parameter int BUS_WIDTH     = DEFAULT_BUS_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic [ADDRESS_WIDTH-1:0] ad,
    input  logic                     st,
    input  logic [BUS_WIDTH-1:0]     x,
    input  logic                     clk,
    output logic [BUS_WIDTH-1:0]     o,
    input  logic                     rst
);

    localparam int DEPTH = ramDepth(ADDRESS_WIDTH);

    logic [DEPTH-1:0]     we;
    logic [BUS_WIDTH-1:0] words [DEPTH];

    // One storage register per address. The one-hot decoder guarantees at
    // most one word loads on any edge; all others hold their value.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign we[i] = st & (ad == ADDRESS_WIDTH'(i));

        ram_word #(
            .WIDTH(BUS_WIDTH)
        ) u_word (
            .clk(clk),
            .rst(rst),
            .we (we[i]),
            .d  (x),
            .q  (words[i])
        );
    end

    // The read path comes purely from stored state. There is deliberately no
    // bypass from x, so o changes on a write only once the word has updated,
    // and it reads zero throughout reset because every word is held cleared.
    assign o = words[ad];

endmodule : ram

// File: tb/tb_ram.sv
// ---------------------------------------------------------------------------
// tb_ram
//
// Directed bench for the register-file RAM. The clock is driven by hand so
// steady-level and falling-edge behaviour can be exercised explicitly.
// Expected read values are queued when stimulus is applied and consumed when
// the output is sampled.
// ---------------------------------------------------------------------------
module tb_ram;

    logic       clk;
    logic       rst;
    logic       st;
    logic [1:0] ad;
    logic [7:0] x;
    logic [7:0] o;

    logic [7:0] mdl [4];
    logic [7:0] sb  [$];

    int passCount  = 0;
    int failCount  = 0;
    int checkCount = 0;

    ram #(
        .BUS_WIDTH    (8),
        .ADDRESS_WIDTH(2)
    ) dut (
        .ad (ad),
        .st (st),
        .x  (x),
        .clk(clk),
        .o  (o),
        .rst(rst)
    );

    // Drive address, store enable and data without touching the clock.
    task automatic applyStimulus(input logic [1:0] a, input logic s, input logic [7:0] d);
        ad = a;
        st = s;
        x  = d;
        #2;
    endtask

    // Rising clock edge; the model writes only when out of reset and storing.
    task automatic clockRise();
        clk = 1'b1;
        if (!rst && st) mdl[ad] = x;
        #5;
    endtask

    task automatic clockFall();
        clk = 1'b0;
        #5;
    endtask

    task automatic assertReset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
        #2;
    endtask

    task automatic releaseReset();
        rst = 1'b0;
        #2;
    endtask

    task automatic expectWord(input logic [7:0] v);
        sb.push_back(v);
    endtask

    task automatic expectModel();
        sb.push_back(mdl[ad]);
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] e;
        checkCount++;
        if (sb.size() == 0) begin
            failCount++;
            $error("[TB] FAIL %s: no expected value queued, o=%h", tag, o);
            return;
        end
        e = sb.pop_front();
        assert (o === e) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: o=%h expected=%h", tag, o, e);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        st  = 1'b0;
        ad  = 2'd0;
        x   = 8'h00;
        #1;

        // 1. Reset clears everything and blocks writes while held
        assertReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'(i), 1'b0, 8'h00);
            expectWord(8'h00);
            checkOutput($sformatf("reset_ad%0d", i));
        end
        applyStimulus(2'd1, 1'b1, 8'hAA);
        clockRise();
        expectWord(8'h00);
        checkOutput("reset_blocks_write");
        clockFall();
        releaseReset();
        applyStimulus(2'd1, 1'b0, 8'hAA);
        expectWord(8'h00);
        checkOutput("after_reset_release");

        // 2. Basic write then read-back via address changes
        applyStimulus(2'd2, 1'b1, 8'd1);
        clockRise();
        expectWord(8'd1);
        checkOutput("write_ad2");
        applyStimulus(2'd0, 1'b1, 8'd1);
        expectWord(8'd0);
        checkOutput("read_ad0");
        applyStimulus(2'd2, 1'b1, 8'd1);
        expectWord(8'd1);
        checkOutput("reread_ad2");

        // 3. Level insensitivity and falling edge never writes
        applyStimulus(2'd2, 1'b1, 8'd30);
        expectWord(8'd1);
        checkOutput("clk_high_x_change");
        applyStimulus(2'd2, 1'b1, 8'd31);
        clockFall();
        expectWord(8'd1);
        checkOutput("falling_edge");
        applyStimulus(2'd2, 1'b1, 8'd32);
        clockRise();
        expectWord(8'd32);
        checkOutput("write_32");
        applyStimulus(2'd2, 1'b1, 8'd33);
        expectWord(8'd32);
        checkOutput("no_bypass");
        clockFall();

        // 4. Store disabled across several edges
        applyStimulus(2'd2, 1'b0, 8'd15);
        for (int i = 0; i < 3; i++) begin
            clockRise();
            clockFall();
        end
        expectWord(8'd32);
        checkOutput("store_disabled");

        // 5. Each address holds its own word
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'(i), 1'b1, 8'(17 * (i + 1)));
            clockRise();
            clockFall();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'(i), 1'b0, 8'h00);
            expectWord(8'(17 * (i + 1)));
            checkOutput($sformatf("indep_ad%0d", i));
        end
        applyStimulus(2'd1, 1'b1, 8'h55);
        clockRise();
        clockFall();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'(i), 1'b0, 8'h00);
            expectModel();
            checkOutput($sformatf("overwrite_ad%0d", i));
        end
        applyStimulus(2'd1, 1'b0, 8'h00);
        expectWord(8'h55);
        checkOutput("overwrite_value");

        // 6. Asynchronous reset with no clock edge, then recovery
        applyStimulus(2'd2, 1'b0, 8'h00);
        assertReset();
        expectWord(8'h00);
        checkOutput("async_reset_ad2");
        applyStimulus(2'd3, 1'b0, 8'h00);
        expectWord(8'h00);
        checkOutput("async_reset_ad3");
        releaseReset();
        applyStimulus(2'd3, 1'b1, 8'h07);
        clockRise();
        clockFall();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'(i), 1'b0, 8'h00);
            expectModel();
            checkOutput($sformatf("post_reset_ad%0d", i));
        end
        applyStimulus(2'd3, 1'b0, 8'h00);
        expectWord(8'h07);
        checkOutput("post_reset_write");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_ram
